uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` serializer between `NREQ` byte producers. It arbitrates per-requester valid/ready byte streams and latches the winning byte into the serializer's message register. It then issues a one-cycle start pulse and tracks the serializer's `ready` line until the frame completes. Packet lock keeps multi-byte messages from interleaving, and watchdogs recover from a stuck serializer.

---
 rtl/uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one uart_tx serializer between NREQ byte producers.
//                Arbitrates valid/ready byte streams, latches the winning byte
//                into the serializer message register, issues a one-cycle
//                start pulse and tracks the serializer ready line until the
//                frame completes. A packet lock keeps multi-byte messages
//                contiguous. Two watchdogs recover from a serializer that
//                never starts (ready stuck high) or never finishes (ready
//                stuck low).
//  Options     : UART_ARB_RR_EN - round-robin selection when defined,
//                fixed priority (lowest index wins) otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          tx_message,
    output logic                tx_start,
    input  logic                tx_ready,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic                locked,
    output logic                err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         DCNT_W      = $clog2(DONE_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // Fourth consecutive ready-high cycle in WAIT_BUSY (counter holds 0..3).
    localparam logic [1:0]        STUCK_LAST = 2'd3;
    // Last WAIT_DONE cycle allowed before the frame is declared lost.
    localparam logic [DCNT_W-1:0] DONE_LAST  = DCNT_W'(DONE_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [7:0]        msg_q,       msg_d;
    logic [2:0]        grant_q,     grant_d;
    logic              locked_q,    locked_d;
    logic              err_q,       err_d;
    logic [1:0]        stuck_cnt_q, stuck_cnt_d;
    logic [DCNT_W-1:0] done_cnt_q,  done_cnt_d;

    logic [NREQ-1:0]   w_eligible;
    logic              w_any;
    logic [2:0]        w_win;
    logic [7:0]        w_win_data;
    logic              w_win_last;
    logic              w_accept;
    logic              w_abort;

`ifdef UART_ARB_RR_EN
    // Index of the most recent winner; the search starts one past it.
    logic [2:0]        rr_ptr_q,    rr_ptr_d;
`endif

    // ------------------------------------------------------------------------
    // Eligibility: while a packet is in flight only its owner may continue.
    // ------------------------------------------------------------------------
    // Mask requests down to the lock owner when the packet lock is held.
    always_comb begin
        w_eligible = req_valid;
        if (locked_q) begin
            for (int j = 0; j < NREQ; j++) begin
                w_eligible[j] = req_valid[j] & (grant_q == 3'(j));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------------
`ifdef UART_ARB_RR_EN
    // Round-robin: scan indices above the pointer first, then wrap to the
    // indices at or below it, which is the same as starting at pointer+1.
    always_comb begin
        w_any = 1'b0;
        w_win = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_any && w_eligible[j] && (3'(j) > rr_ptr_q)) begin
                w_any = 1'b1;
                w_win = 3'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_any && w_eligible[j] && (3'(j) <= rr_ptr_q)) begin
                w_any = 1'b1;
                w_win = 3'(j);
            end
        end
    end

    // Pointer follows the winner, and moves only when a byte is accepted.
    always_comb begin
        rr_ptr_d = w_accept ? w_win : rr_ptr_q;
    end

    // Pointer register; reset to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 3'(NREQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: the lowest eligible index wins.
    always_comb begin
        w_any = 1'b0;
        w_win = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_any && w_eligible[j]) begin
                w_any = 1'b1;
                w_win = 3'(j);
            end
        end
    end
`endif

    // Route the winner's byte and last flag towards the message register.
    always_comb begin
        w_win_data = 8'h00;
        w_win_last = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == 3'(j)) begin
                w_win_data = req_data[8*j +: 8];
                w_win_last = req_last[j];
            end
        end
    end

    // A byte is only offered when idle and the serializer reports idle too.
    assign w_accept = (state_q == S_IDLE) && tx_ready && w_any;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including both watchdog aborts.
    always_comb begin
        state_d = state_q;
        w_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The serializer samples start in ISSUE and drops ready in
                // the following cycle; if it never does, give up.
                if (!tx_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (stuck_cnt_q == STUCK_LAST) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = S_IDLE;
                end else if (done_cnt_q == DONE_LAST) begin
                    state_d = S_IDLE;
                    w_abort = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake, start pulse and busy flag.
    always_comb begin
        req_ready = '0;
        tx_start  = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        if (w_accept) begin
            for (int j = 0; j < NREQ; j++) begin
                req_ready[j] = (w_win == 3'(j));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Next values for the message, grant, lock, error and watchdog counters.
    always_comb begin
        msg_d    = msg_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        err_d    = w_abort;

        if (w_accept) begin
            msg_d    = w_win_data;
            grant_d  = w_win;
            locked_d = ~w_win_last;
        end else if (w_abort) begin
            locked_d = 1'b0;
        end

        // Counters run only while staying in their state, so entry is zero.
        stuck_cnt_d = ((state_q == S_WAIT_BUSY) && (state_d == S_WAIT_BUSY))
                    ? stuck_cnt_q + 2'd1 : 2'd0;
        done_cnt_d  = ((state_q == S_WAIT_DONE) && (state_d == S_WAIT_DONE))
                    ? done_cnt_q + DCNT_W'(1) : '0;
    end

    // Datapath registers; a reset mid-frame abandons the frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_q       <= 8'h00;
            grant_q     <= 3'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            stuck_cnt_q <= 2'd0;
            done_cnt_q  <= '0;
        end else begin
            msg_q       <= msg_d;
            grant_q     <= grant_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            stuck_cnt_q <= stuck_cnt_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign tx_message = msg_q;
    assign grant_id   = grant_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter with a
//                small behavioural serializer (normal / ignores start /
//                never finishes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ         = 4;
    localparam int DONE_TIMEOUT = 64;
    localparam int FRAME        = 20;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data  = 32'h0;
    logic [3:0]  req_last  = 4'b0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_message;
    logic        tx_start;
    logic        tx_ready  = 1'b1;
    logic [2:0]  grant_id;
    logic        busy;
    logic        locked;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Serializer model controls: 0 normal, 1 ignores start, 2 never finishes.
    int   model_mode = 0;
    int   model_len  = FRAME;
    logic model_rel  = 1'b0;
    int   model_cnt  = 0;

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_message (tx_message),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .locked     (locked),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural uart_tx: samples start, drops ready next cycle, holds it
    // low for model_len cycles.
    always @(posedge clk) begin
        if (model_rel) begin
            tx_ready  <= 1'b1;
            model_cnt <= 0;
        end else if (model_cnt == 1) begin
            tx_ready  <= 1'b1;
            model_cnt <= 0;
        end else if (model_cnt > 1) begin
            model_cnt <= model_cnt - 1;
        end else if (tx_start && model_mode != 1) begin
            tx_ready  <= 1'b0;
            model_cnt <= (model_mode == 2) ? 1000000 : model_len;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Waits for a non-zero req_ready; leaves time inside the accept cycle.
    task automatic wait_accept(output logic [3:0] rr, output bit ok);
        ok = 1'b0;
        rr = 4'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (req_ready !== 4'b0) begin
                rr = req_ready;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        req_valid  = 4'b0;
        req_last   = 4'b0;
        model_mode = 0;
        model_len  = FRAME;
        model_rel  = 1'b1;
        tick();
        model_rel  = 1'b0;
        tick();
        rst        = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if (req_ready !== 4'b0)  begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (tx_start !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_message !== 8'h00) begin n_bad++; $display("FAIL reset_tx_message: got %h want 00", tx_message); end
        n_cmp++; if (grant_id !== 3'd0)   begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if ({busy, locked, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: busy/locked/err got %b want 000", {busy, locked, err}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        bit seen;
        bit stable;
        do_reset();
        req_data[23:16] = 8'hA4;
        req_last        = 4'b0100;
        req_valid       = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0;
        #1;
        n_cmp++; if (tx_start !== 1'b1)    begin n_bad++; $display("FAIL single_start: got %b want 1", tx_start); end
        n_cmp++; if (tx_message !== 8'hA4) begin n_bad++; $display("FAIL single_msg: got %h want a4", tx_message); end
        n_cmp++; if (grant_id !== 3'd2)    begin n_bad++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        n_cmp++; if ({busy, locked} !== 2'b10) begin n_bad++; $display("FAIL single_busy_locked: got %b want 10", {busy, locked}); end
        tick();
        n_cmp++; if (tx_start !== 1'b0)    begin n_bad++; $display("FAIL single_start_pulse: got %b want 0", tx_start); end
        seen   = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (tx_message !== 8'hA4) stable = 1'b0;
            if (tx_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++; if (!seen || !stable) begin n_bad++; $display("FAIL single_frame: ready_seen %b msg_stable %b want 1 1", seen, stable); end
        n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL single_busy_at_ready: got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_contention;
        logic [3:0] rr;
        bit         ok;
        int         prev;
        int         expw;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        prev      = 0;
        for (int k = 0; k < 8; k++) begin
`ifdef UART_ARB_RR_EN
            expw = k % 4;
`else
            expw = 0;
`endif
            wait_accept(rr, ok);
            n_cmp++; if (!ok || rr !== 4'(1 << expw)) begin n_bad++; $display("FAIL contention_grant[%0d]: got %b want %b", k, rr, 4'(1 << expw)); end
            if (k > 0) begin
                n_cmp++; if (cyc - prev !== FRAME + 3) begin n_bad++; $display("FAIL contention_gap[%0d]: got %0d want %0d", k, cyc - prev, FRAME + 3); end
            end
            prev = cyc;
            tick();
            n_cmp++; if (tx_message !== 8'(8'h10 + expw) || grant_id !== 3'(expw)) begin n_bad++; $display("FAIL contention_msg[%0d]: got %h/%0d want %h/%0d", k, tx_message, grant_id, 8'(8'h10 + expw), expw); end
        end
        req_valid = 4'b0;
    endtask

    task automatic test_packet_lock;
        logic [3:0] rr;
        bit         ok;
        do_reset();
        req_data[7:0]  = 8'h55;
        req_data[15:8] = 8'hB1;
        req_last       = 4'b0001;
        req_valid      = 4'b0010;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0010) begin n_bad++; $display("FAIL lock_first: got %b want 0010", rr); end
        tick();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_set: got %b want 1", locked); end
        req_valid      = 4'b0011;
        req_data[15:8] = 8'hB2;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0010) begin n_bad++; $display("FAIL lock_second: got %b want 0010", rr); end
        tick();
        n_cmp++; if (tx_message !== 8'hB2) begin n_bad++; $display("FAIL lock_second_msg: got %h want b2", tx_message); end
        req_data[15:8] = 8'hB3;
        req_last       = 4'b0011;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0010 || locked !== 1'b1) begin n_bad++; $display("FAIL lock_third: got %b locked %b want 0010 locked 1", rr, locked); end
        tick();
        n_cmp++; if (locked !== 1'b0 || tx_message !== 8'hB3) begin n_bad++; $display("FAIL lock_release: locked %b msg %h want 0 b3", locked, tx_message); end
        req_valid = 4'b0001;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0001) begin n_bad++; $display("FAIL lock_then_req0: got %b want 0001", rr); end
        tick();
        req_valid = 4'b0;
    endtask

    task automatic test_stuck_ready;
        logic [3:0] rr;
        bit         ok;
        do_reset();
        model_mode      = 1;
        req_data[31:24] = 8'h3C;
        req_last        = 4'b0000;
        req_valid       = 4'b1000;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b1000) begin n_bad++; $display("FAIL stuck_accept: got %b want 1000", rr); end
        tick();
        req_valid = 4'b0;
        n_cmp++; if ({tx_start, locked} !== 2'b11) begin n_bad++; $display("FAIL stuck_issue: start/locked got %b want 11", {tx_start, locked}); end
        repeat (4) tick();
        n_cmp++; if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL stuck_before: err/busy got %b want 01", {err, busy}); end
        tick();
        n_cmp++; if ({err, busy, locked} !== 3'b100) begin n_bad++; $display("FAIL stuck_abort: err/busy/locked got %b want 100", {err, busy, locked}); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL stuck_err_pulse: got %b want 0", err); end
        model_mode = 0;
    endtask

    task automatic test_done_timeout;
        logic [3:0] rr;
        bit         ok;
        do_reset();
        model_mode      = 2;
        req_data[15:8]  = 8'h77;
        req_last        = 4'b0010;
        req_valid       = 4'b0010;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0010) begin n_bad++; $display("FAIL timeout_accept: got %b want 0010", rr); end
        tick();
        req_valid = 4'b0;
        repeat (65) tick();
        n_cmp++; if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL timeout_before: err/busy got %b want 01", {err, busy}); end
        tick();
        n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++; $display("FAIL timeout_abort: err/busy got %b want 10", {err, busy}); end
        req_data[23:16] = 8'h99;
        req_last        = 4'b0100;
        req_valid       = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL timeout_no_accept: got %b want 0000", req_ready); end
        model_mode = 0;
        model_rel  = 1'b1;
        tick();
        model_rel  = 1'b0;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0100) begin n_bad++; $display("FAIL timeout_next: got %b want 0100", rr); end
        tick();
        req_valid = 4'b0;
        n_cmp++; if (tx_message !== 8'h99) begin n_bad++; $display("FAIL timeout_next_msg: got %h want 99", tx_message); end
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] rr;
        bit         ok;
        bit         quiet;
        bit         seen;
        do_reset();
        model_len     = 40;
        req_data[7:0] = 8'h5A;
        req_last      = 4'b0000;
        req_valid     = 4'b0001;
        wait_accept(rr, ok);
        n_cmp++; if (!ok || rr !== 4'b0001) begin n_bad++; $display("FAIL midrst_accept: got %b want 0001", rr); end
        tick();
        repeat (4) tick();
        n_cmp++; if ({busy, locked} !== 2'b11) begin n_bad++; $display("FAIL midrst_inframe: busy/locked got %b want 11", {busy, locked}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if ({busy, locked, err, tx_start} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags: busy/locked/err/start got %b want 0000", {busy, locked, err, tx_start}); end
        n_cmp++; if (tx_message !== 8'h00 || grant_id !== 3'd0) begin n_bad++; $display("FAIL midrst_regs: msg %h grant %0d want 00 0", tx_message, grant_id); end
        quiet = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (req_ready !== 4'b0 || err !== 1'b0) quiet = 1'b0;
            tick();
            #1;
        end
        n_cmp++; if (!seen || !quiet) begin n_bad++; $display("FAIL midrst_wait: ready_seen %b quiet %b want 1 1", seen, quiet); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midrst_resume: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_stuck_ready();
        test_done_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
